usb_fs_out_ep_buf: RTL and testbench
====================================

Name: usb_fs_out_ep_buf

Overview:
Single-packet OUT/SETUP receive buffer between the USB protocol engine (bus side) and an OUT endpoint consumer such as the serial control endpoint. It captures one data packet's payload and tracks the DATA0/DATA1 toggle. It decides the ACK/NAK/STALL handshake and presents accepted bytes through the req/grant/avail/get endpoint interface.

Parameters:
MAX_PKT_SIZE, 32, payload buffer depth in bytes (power of two, 8..64).
PTR_W, 6, pointer/length width; must satisfy 2**PTR_W > MAX_PKT_SIZE.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
bus_xfr_start  input  1  pulse: OUT or SETUP token addressed to this endpoint
bus_xfr_setup  input  1  qualifies bus_xfr_start: 1 = SETUP token
bus_data_put  input  1  payload byte strobe (CRC bytes excluded)
bus_data  input  8  payload byte, valid with bus_data_put
bus_data_toggle  input  1  received data PID: 0 = DATA0, 1 = DATA1; valid with end pulses
bus_xfr_end_ok  input  1  pulse: data packet ended, CRC good
bus_xfr_end_bad  input  1  pulse: data packet ended with CRC/bit-stuff error or timeout
bus_handshake_valid  output  1  pulse: handshake decision ready
bus_handshake  output  2  0 none, 1 ACK, 2 NAK, 3 STALL; valid with bus_handshake_valid
out_ep_req  input  1  consumer requests buffer access
out_ep_grant  output  1  access granted
out_ep_data_avail  output  1  unread bytes held
out_ep_setup  output  1  held packet came from a SETUP transaction
out_ep_data_get  input  1  consumer pops one byte (honoured only with grant)
out_ep_data  output  8  popped byte, registered
out_ep_stall  input  1  consumer requests STALL on OUT transactions
out_ep_acked  output  1  pulse: packet accepted and ACKed

Behaviour:
- Reset: all outputs 0; state READY; wr_ptr = rd_ptr = len = 0; expected toggle 0; overflow 0; setup flag 0. Reset mid-packet discards everything and emits no handshake.
- States: READY (empty, accepting), RX (capturing), HOLD (accepted packet unread), DISCARD (sinking a packet that will not be stored).
- READY/HOLD/RX/DISCARD + bus_xfr_start:
  - if bus_xfr_setup: go RX; clear wr_ptr/overflow; flush any HOLD contents (SETUP always wins).
  - else if state is HOLD: go DISCARD with pending verdict NAK.
  - else if out_ep_stall: go DISCARD with verdict STALL.
  - else: go RX.
  - Start while in RX restarts capture (previous packet abandoned, no handshake).
- RX: each bus_data_put writes mem[wr_ptr] and increments wr_ptr while wr_ptr < MAX_PKT_SIZE. A put at wr_ptr == MAX_PKT_SIZE sets overflow; the byte is dropped.
- bus_xfr_end_bad in RX/DISCARD: no handshake; return to READY, or to HOLD if a held packet is retained (NAK case).
- bus_xfr_end_ok in RX, decided the following cycle (bus_handshake_valid 1 cycle after end pulse):
  - overflow set, or SETUP with DATA1: no handshake; go READY.
  - OUT with toggle != expected: ACK; discard; toggle unchanged; no out_ep_acked; go READY.
  - otherwise: ACK; out_ep_acked pulses in the same cycle; len = wr_ptr; expected toggle = 1 after SETUP, else inverted.
    - go HOLD if len > 0, else READY (zero-length packet: acked only).
- bus_xfr_end_ok in DISCARD: emit the pending NAK or STALL; return to the prior state (HOLD retained on NAK).
- HOLD:
  - out_ep_data_avail = 1 while rd_ptr < len.
  - out_ep_setup = setup flag of the held packet; setup flag is 0 when data_avail is 0.
  - out_ep_grant = out_ep_req && out_ep_data_avail (combinational).
  - get && grant: out_ep_data <= mem[rd_ptr] on the next edge (1-cycle latency); rd_ptr++.
  - Last byte popped: data_avail drops the same edge; state READY; rd_ptr = 0.
- get without grant is ignored. out_ep_stall never affects SETUP.
- Simultaneous end_ok and bus_xfr_start: start takes precedence; the ended packet gets no handshake.

Test Plan:
- SETUP + DATA0 8 bytes 80 06 00 01 00 00 40 00 -> ACK + out_ep_acked at end+1; data_avail/setup high; 8 gets yield same bytes 1 cycle later; avail falls after 8th get.
- After the SETUP, OUT DATA1 3 bytes then OUT DATA1 again -> first ACK/acked; second ACK, no acked, buffer unchanged; next expected toggle 0.
- OUT while HOLD with 5 unread bytes -> NAK; held data intact; then SETUP -> flushes, ACK, new data presented.
- out_ep_stall=1: OUT DATA0 -> STALL, no acked; SETUP DATA0 -> ACK.
- 33-byte OUT with MAX_PKT_SIZE=32 -> no handshake, READY, data_avail stays 0; OUT with end_bad -> no handshake.
- Zero-length OUT DATA1 in status stage -> ACK + acked pulse; data_avail never rises; reset asserted mid-RX -> no handshake, all outputs 0.

Source files
------------

// File: rtl/usb_fs_out_ep_buf.sv
// rtl/usb_fs_out_ep_buf.sv - single-packet OUT/SETUP receive buffer with toggle tracking
// Captures one payload, decides ACK/NAK/STALL and serves bytes over the endpoint req/grant/get interface.
module usb_fs_out_ep_buf #(
  parameter int MAX_PKT_SIZE = 32,
  parameter int PTR_W        = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_xfr_start,
  input  logic       bus_xfr_setup,
  input  logic       bus_data_put,
  input  logic [7:0] bus_data,
  input  logic       bus_data_toggle,
  input  logic       bus_xfr_end_ok,
  input  logic       bus_xfr_end_bad,
  output logic       bus_handshake_valid,
  output logic [1:0] bus_handshake,
  input  logic       out_ep_req,
  output logic       out_ep_grant,
  output logic       out_ep_data_avail,
  output logic       out_ep_setup,
  input  logic       out_ep_data_get,
  output logic [7:0] out_ep_data,
  input  logic       out_ep_stall,
  output logic       out_ep_acked
);

  localparam int AW = $clog2(MAX_PKT_SIZE);
  localparam logic [PTR_W-1:0] MAX_LEN = PTR_W'(MAX_PKT_SIZE);

  localparam logic [1:0] ST_READY   = 2'd0;
  localparam logic [1:0] ST_RX      = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [1:0] HS_NONE  = 2'd0;
  localparam logic [1:0] HS_ACK   = 2'd1;
  localparam logic [1:0] HS_NAK   = 2'd2;
  localparam logic [1:0] HS_STALL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] len_q, len_d;
  logic             exp_tog_q, exp_tog_d;
  logic             ovf_q, ovf_d;
  logic             rx_setup_q, rx_setup_d;
  logic             setup_flag_q, setup_flag_d;
  logic [1:0]       verdict_q, verdict_d;
  logic             hs_valid_q, hs_valid_d;
  logic [1:0]       hs_q, hs_d;
  logic             acked_q, acked_d;
  logic [7:0]       out_data_q, out_data_d;

  logic [7:0]    mem_q [MAX_PKT_SIZE];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          pop;

  assign out_ep_data_avail   = (rd_ptr_q < len_q);
  assign out_ep_grant        = out_ep_req && out_ep_data_avail;
  assign out_ep_setup        = setup_flag_q && out_ep_data_avail;
  assign out_ep_data         = out_data_q;
  assign out_ep_acked        = acked_q;
  assign bus_handshake_valid = hs_valid_q;
  assign bus_handshake       = hs_q;
  assign pop                 = out_ep_data_get && out_ep_grant;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    len_d        = len_q;
    exp_tog_d    = exp_tog_q;
    ovf_d        = ovf_q;
    rx_setup_d   = rx_setup_q;
    setup_flag_d = setup_flag_q;
    verdict_d    = verdict_q;
    hs_valid_d   = 1'b0;
    hs_d         = HS_NONE;
    acked_d      = 1'b0;
    out_data_d   = out_data_q;
    mem_we       = 1'b0;
    mem_waddr    = wr_ptr_q[AW-1:0];

    // Popping runs first so a same-cycle start sees whether anything is still held.
    if (pop) begin
      out_data_d = mem_q[rd_ptr_q[AW-1:0]];
      if (rd_ptr_q + PTR_W'(1) == len_q) begin
        rd_ptr_d     = '0;
        len_d        = '0;
        setup_flag_d = 1'b0;
        if (state_q == ST_HOLD) state_d = ST_READY;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end

    if (bus_xfr_start) begin
      if (bus_xfr_setup) begin
        state_d      = ST_RX;
        wr_ptr_d     = '0;
        ovf_d        = 1'b0;
        rx_setup_d   = 1'b1;
        len_d        = '0;
        rd_ptr_d     = '0;
        setup_flag_d = 1'b0;
      end else if (len_d != '0) begin
        state_d   = ST_DISCARD;
        verdict_d = HS_NAK;
      end else if (out_ep_stall) begin
        state_d   = ST_DISCARD;
        verdict_d = HS_STALL;
      end else begin
        state_d    = ST_RX;
        wr_ptr_d   = '0;
        ovf_d      = 1'b0;
        rx_setup_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_RX: begin
          if (bus_data_put) begin
            if (wr_ptr_q < MAX_LEN) begin
              mem_we   = 1'b1;
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
          if (bus_xfr_end_bad) begin
            state_d = ST_READY;
          end else if (bus_xfr_end_ok) begin
            if (ovf_q || (rx_setup_q && bus_data_toggle)) begin
              state_d = ST_READY;
            end else if (!rx_setup_q && (bus_data_toggle != exp_tog_q)) begin
              // Retransmission of a packet we already took: ACK it again, keep nothing.
              hs_valid_d = 1'b1;
              hs_d       = HS_ACK;
              state_d    = ST_READY;
            end else begin
              hs_valid_d   = 1'b1;
              hs_d         = HS_ACK;
              acked_d      = 1'b1;
              len_d        = wr_ptr_q;
              rd_ptr_d     = '0;
              setup_flag_d = rx_setup_q;
              exp_tog_d    = rx_setup_q ? 1'b1 : ~exp_tog_q;
              state_d      = (wr_ptr_q != '0) ? ST_HOLD : ST_READY;
            end
          end
        end
        ST_DISCARD: begin
          if (bus_xfr_end_bad) begin
            state_d = (len_d != '0) ? ST_HOLD : ST_READY;
          end else if (bus_xfr_end_ok) begin
            hs_valid_d = 1'b1;
            hs_d       = verdict_q;
            state_d    = (len_d != '0) ? ST_HOLD : ST_READY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_READY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      exp_tog_q    <= 1'b0;
      ovf_q        <= 1'b0;
      rx_setup_q   <= 1'b0;
      setup_flag_q <= 1'b0;
      verdict_q    <= HS_NONE;
      hs_valid_q   <= 1'b0;
      hs_q         <= HS_NONE;
      acked_q      <= 1'b0;
      out_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      exp_tog_q    <= exp_tog_d;
      ovf_q        <= ovf_d;
      rx_setup_q   <= rx_setup_d;
      setup_flag_q <= setup_flag_d;
      verdict_q    <= verdict_d;
      hs_valid_q   <= hs_valid_d;
      hs_q         <= hs_d;
      acked_q      <= acked_d;
      out_data_q   <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= bus_data;
  end

endmodule

// File: tb/tb_usb_fs_out_ep_buf.sv
// tb/tb_usb_fs_out_ep_buf.sv - directed self-checking bench for usb_fs_out_ep_buf
module tb_usb_fs_out_ep_buf;
  logic       clk;
  logic       reset;
  logic       bus_xfr_start, bus_xfr_setup, bus_data_put;
  logic [7:0] bus_data;
  logic       bus_data_toggle, bus_xfr_end_ok, bus_xfr_end_bad;
  logic       bus_handshake_valid;
  logic [1:0] bus_handshake;
  logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data_get;
  logic [7:0] out_ep_data;
  logic       out_ep_stall, out_ep_acked;

  int checks = 0;
  int failures = 0;

  logic [7:0] pkt  [64];
  logic [7:0] held [64];
  logic       hv, ak;
  logic [1:0] hs;

  usb_fs_out_ep_buf #(.MAX_PKT_SIZE(32), .PTR_W(6)) dut (
    .clk(clk), .reset(reset),
    .bus_xfr_start(bus_xfr_start), .bus_xfr_setup(bus_xfr_setup),
    .bus_data_put(bus_data_put), .bus_data(bus_data), .bus_data_toggle(bus_data_toggle),
    .bus_xfr_end_ok(bus_xfr_end_ok), .bus_xfr_end_bad(bus_xfr_end_bad),
    .bus_handshake_valid(bus_handshake_valid), .bus_handshake(bus_handshake),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant), .out_ep_data_avail(out_ep_data_avail),
    .out_ep_setup(out_ep_setup), .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
    .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 64; i++) pkt[i] = base + 8'(i);
  endtask

  task automatic snap();
    for (int i = 0; i < 64; i++) held[i] = pkt[i];
  endtask

  task automatic xfer(input bit setup, input int n, input bit tog, input bit ok,
                      output logic o_hv, output logic [1:0] o_hs, output logic o_ak);
    bus_xfr_start = 1'b1;
    bus_xfr_setup = setup;
    @(posedge clk); #1;
    bus_xfr_start = 1'b0;
    bus_xfr_setup = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_data_put = 1'b1;
      bus_data     = pkt[i];
      @(posedge clk); #1;
    end
    bus_data_put    = 1'b0;
    bus_data_toggle = tog;
    if (ok) bus_xfr_end_ok = 1'b1;
    else    bus_xfr_end_bad = 1'b1;
    @(posedge clk); #1;
    bus_xfr_end_ok  = 1'b0;
    bus_xfr_end_bad = 1'b0;
    o_hv = bus_handshake_valid;
    o_hs = bus_handshake;
    o_ak = out_ep_acked;
  endtask

  task automatic pop_check(input int n, input int start);
    out_ep_req = 1'b1;
    for (int i = 0; i < n; i++) begin
      out_ep_data_get = 1'b1;
      @(posedge clk); #1;
      check("pop_data", {24'h0, out_ep_data}, {24'h0, held[start+i]});
    end
    out_ep_data_get = 1'b0;
    out_ep_req      = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus_xfr_start = 0; bus_xfr_setup = 0; bus_data_put = 0; bus_data = 0;
    bus_data_toggle = 0; bus_xfr_end_ok = 0; bus_xfr_end_bad = 0;
    out_ep_req = 0; out_ep_data_get = 0; out_ep_stall = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {16'h0, bus_handshake_valid, bus_handshake, out_ep_grant,
          out_ep_data_avail, out_ep_setup, out_ep_acked, out_ep_data}, 32'h0);
    reset = 1'b0;

    // SETUP with standard GET_DESCRIPTOR request
    pkt[0] = 8'h80; pkt[1] = 8'h06; pkt[2] = 8'h00; pkt[3] = 8'h01;
    pkt[4] = 8'h00; pkt[5] = 8'h00; pkt[6] = 8'h40; pkt[7] = 8'h00;
    snap();
    xfer(1, 8, 0, 1, hv, hs, ak);
    check("setup1_hs", {29'h0, hv, hs}, {29'h0, 1'b1, 2'd1});
    check("setup1_acked", {31'h0, ak}, 32'h1);
    check("setup1_avail_setup", {30'h0, out_ep_data_avail, out_ep_setup}, 32'h3);
    out_ep_req = 1'b1; #1;
    check("setup1_grant", {31'h0, out_ep_grant}, 32'h1);
    pop_check(8, 0);
    check("setup1_drained", {30'h0, out_ep_data_avail, out_ep_grant}, 32'h0);

    // OUT DATA1 accepted, then its retransmission is ACKed but dropped
    fill(8'h30); snap();
    xfer(0, 3, 1, 1, hv, hs, ak);
    check("out1_hs", {29'h0, hv, hs}, {29'h0, 1'b1, 2'd1});
    check("out1_acked", {31'h0, ak}, 32'h1);
    check("out1_avail_setup", {30'h0, out_ep_data_avail, out_ep_setup}, 32'h2);
    pop_check(3, 0);
    fill(8'h40);
    xfer(0, 2, 1, 1, hv, hs, ak);
    check("dup_hs", {29'h0, hv, hs}, {29'h0, 1'b1, 2'd1});
    check("dup_acked", {31'h0, ak}, 32'h0);
    check("dup_avail", {31'h0, out_ep_data_avail}, 32'h0);
    fill(8'h48); snap();
    xfer(0, 1, 0, 1, hv, hs, ak);
    check("tog0_acked", {29'h0, hv, hs, ak} , {29'h0, 1'b1, 2'd1, 1'b1});
    pop_check(1, 0);

    // OUT while holding unread bytes is NAKed; SETUP then flushes
    fill(8'h50); snap();
    xfer(0, 5, 1, 1, hv, hs, ak);
    check("hold5_acked", {29'h0, hv, hs, ak}, {29'h0, 1'b1, 2'd1, 1'b1});
    fill(8'h70);
    xfer(0, 2, 0, 1, hv, hs, ak);
    check("nak_hs", {29'h0, hv, hs}, {29'h0, 1'b1, 2'd2});
    check("nak_acked", {31'h0, ak}, 32'h0);
    check("nak_avail", {31'h0, out_ep_data_avail}, 32'h1);
    pop_check(1, 0);
    pkt[0] = 8'h00; pkt[1] = 8'h09; pkt[2] = 8'h01; pkt[3] = 8'h00;
    pkt[4] = 8'h00; pkt[5] = 8'h00; pkt[6] = 8'h00; pkt[7] = 8'h00;
    snap();
    xfer(1, 8, 0, 1, hv, hs, ak);
    check("flush_setup_hs", {29'h0, hv, hs, ak}, {29'h0, 1'b1, 2'd1, 1'b1});
    check("flush_setup_flag", {30'h0, out_ep_data_avail, out_ep_setup}, 32'h3);
    pop_check(8, 0);
    check("flush_drained", {31'h0, out_ep_data_avail}, 32'h0);

    // Consumer stall affects OUT only
    out_ep_stall = 1'b1;
    fill(8'h90);
    xfer(0, 2, 1, 1, hv, hs, ak);
    check("stall_hs", {29'h0, hv, hs}, {29'h0, 1'b1, 2'd3});
    check("stall_acked", {31'h0, ak}, 32'h0);
    fill(8'hA0); snap();
    xfer(1, 8, 0, 1, hv, hs, ak);
    check("stall_setup_hs", {29'h0, hv, hs, ak}, {29'h0, 1'b1, 2'd1, 1'b1});
    pop_check(8, 0);
    out_ep_stall = 1'b0;

    // Oversized packet and CRC-bad packet get no handshake
    fill(8'h00);
    xfer(0, 33, 1, 1, hv, hs, ak);
    check("ovf_hs", {30'h0, hv, ak}, 32'h0);
    check("ovf_avail", {31'h0, out_ep_data_avail}, 32'h0);
    fill(8'hC0);
    xfer(0, 4, 1, 0, hv, hs, ak);
    check("bad_hs", {30'h0, hv, ak}, 32'h0);
    check("bad_avail", {31'h0, out_ep_data_avail}, 32'h0);

    // Zero-length status-stage OUT
    xfer(0, 0, 1, 1, hv, hs, ak);
    check("zlp_hs", {29'h0, hv, hs, ak}, {29'h0, 1'b1, 2'd1, 1'b1});
    check("zlp_avail", {31'h0, out_ep_data_avail}, 32'h0);

    // Reset in the middle of a packet
    fill(8'hE0);
    bus_xfr_start = 1'b1;
    @(posedge clk); #1;
    bus_xfr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_data_put = 1'b1; bus_data = pkt[i];
      @(posedge clk); #1;
    end
    bus_data_put = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_outputs", {16'h0, bus_handshake_valid, bus_handshake, out_ep_grant,
          out_ep_data_avail, out_ep_setup, out_ep_acked, out_ep_data}, 32'h0);
    bus_data_toggle = 1'b0;
    bus_xfr_end_ok  = 1'b1;
    @(posedge clk); #1;
    bus_xfr_end_ok  = 1'b0;
    check("midreset_no_hs", {30'h0, bus_handshake_valid, out_ep_acked}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
